reg_bank_p: RTL and testbench

REG_BANK_P -- requirements
Module: reg_bank_p

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_p_cell.sv | 43 ++++
 rtl/reg_bank_p.sv | 134 +++++++++++++
 tb/tb_reg_bank_p.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg -- shared definitions for the reg_bank_p register file.
//   mem_state_e : memory-transaction FSM states (IDLE, READ, WRITE)
//   SEL_DR/AR   : offsets added to NREG to select DR and AR on the read mux
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mem_state_e;

  localparam int SEL_DR = 0;
  localparam int SEL_AR = 1;

endpackage

// File: rtl/reg_bank_p_cell.sv
// reg_cell_incdec -- one general-purpose register with load / increment /
// decrement.
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   we         : load d (highest priority)
//   inc, dec   : +1 / -1 with wrap-around; both high holds the value
//   d          : load data
//   q          : register value
module reg_cell_incdec #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              inc,
  input  logic              dec,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = d;
    end else if (inc ^ dec) begin
      // Modular arithmetic gives the required wrap in both directions.
      q_d = inc ? q_q + 1'b1 : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_bank_p.sv
// reg_bank_p -- bank of NREG incrementable registers plus AR/DR/IR and a
// single-outstanding memory transaction FSM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   c_bus_in              : shared write data for general regs, AR, DR
//   we/inc/dec [NREG]     : per-register load / increment / decrement
//   ar_we, dr_we          : load AR / DR (ignored while busy)
//   sel, mux_out          : read mux (0..NREG-1 regs, NREG DR, NREG+1 AR, else 0)
//   mem_rd, mem_wr        : transaction start pulses (accepted only in IDLE)
//   mem_req/mem_we/busy   : transaction status
//   mem_addr, mem_wdata   : AR, DR
//   mem_rdata, mem_ack    : read data and completion from memory
//   ir_ld, ir_out         : load IR from low bits of DR, IR value
//   reg_zero              : per-register zero flags
module reg_bank_p
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IR_W   = 6,
  parameter int SEL_W  = $clog2(NREG + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c_bus_in,
  input  logic [NREG-1:0]   we,
  input  logic [NREG-1:0]   inc,
  input  logic [NREG-1:0]   dec,
  input  logic              ar_we,
  input  logic              dr_we,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] mux_out,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              ir_ld,
  output logic [IR_W-1:0]   ir_out,
  output logic [NREG-1:0]   reg_zero
);

  logic [DATA_W-1:0] reg_q [NREG];

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    reg_cell_incdec #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[g]),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .d     (c_bus_in),
      .q     (reg_q[g])
    );
  end

  // Read mux and zero flags
  always_comb begin
    mux_out = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == SEL_W'(i)) mux_out = reg_q[i];
    end
    if (sel == SEL_W'(NREG + SEL_DR)) mux_out = dr_q;
    if (sel == SEL_W'(NREG + SEL_AR)) mux_out = ar_q;
  end

  always_comb begin
    reg_zero = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_zero[i] = (reg_q[i] == '0);
    end
  end

  // Memory FSM next state; mem_rd wins over mem_wr when both pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_rd)      state_d = READ;
        else if (mem_wr) state_d = WRITE;
      end
      READ, WRITE: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // AR/DR frozen during a transaction so address and write data stay
  // stable; the read ack is the only way DR changes while busy.
  always_comb begin
    ar_d = ar_q;
    dr_d = dr_q;
    ir_d = ir_q;
    if (state_q == IDLE && ar_we) ar_d = c_bus_in;
    if (state_q == READ && mem_ack) begin
      dr_d = mem_rdata;
    end else if (state_q == IDLE && dr_we) begin
      dr_d = c_bus_in;
    end
    // Uses current DR, so a coincident read ack is not seen by IR.
    if (ir_ld) ir_d = dr_q[IR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ar_q    <= '0;
      dr_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      dr_q    <= dr_d;
      ir_q    <= ir_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = busy;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = ar_q;
  assign mem_wdata = dr_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_reg_bank_p.sv
// tb_reg_bank_p -- directed self-checking bench for reg_bank_p with default
// parameters (DATA_W=16, NREG=8, IR_W=6, SEL_W=4).
module tb_reg_bank_p;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int IR_W   = 6;
  localparam int SEL_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] c_bus_in;
  logic [NREG-1:0]   we, inc, dec;
  logic              ar_we, dr_we;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_out;
  logic              mem_rd, mem_wr;
  logic              mem_req, mem_we, busy;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              ir_ld;
  logic [IR_W-1:0]   ir_out;
  logic [NREG-1:0]   reg_zero;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  reg_bank_p #(.DATA_W(DATA_W), .NREG(NREG), .IR_W(IR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c_bus_in  (c_bus_in),
    .we        (we),
    .inc       (inc),
    .dec       (dec),
    .ar_we     (ar_we),
    .dr_we     (dr_we),
    .sel       (sel),
    .mux_out   (mux_out),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir_ld     (ir_ld),
    .ir_out    (ir_out),
    .reg_zero  (reg_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setsel(input logic [SEL_W-1:0] v);
    sel = v;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; c_bus_in = '0; we = '0; inc = '0; dec = '0;
    ar_we = 1'b0; dr_we = 1'b0; sel = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0; ir_ld = 1'b0;
    #3;
    chk("rst_mux0", 32'(mux_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_zero", 32'(reg_zero), 32'hFF);
    chk("rst_ir", 32'(ir_out), 32'h0);
    step(); step();
    rst_n = 1'b1;

    // Load reg3 and read it back
    we = 8'h08; c_bus_in = 16'h1234;
    step();
    we = '0;
    setsel(4'd3);
    chk("r3_load", 32'(mux_out), 32'h1234);
    chk("r3_zero", 32'(reg_zero), 32'hF7);

    // Wrap-around and priority on reg2
    we = 8'h04; c_bus_in = 16'hFFFF;
    step();
    we = '0; inc = 8'h04;
    step();
    inc = '0;
    setsel(4'd2);
    chk("r2_inc_wrap", 32'(mux_out), 32'h0000);
    dec = 8'h04;
    step();
    dec = '0;
    chk("r2_dec_wrap", 32'(mux_out), 32'hFFFF);
    inc = 8'h04; dec = 8'h04;
    step();
    inc = '0; dec = '0;
    chk("r2_both_hold", 32'(mux_out), 32'hFFFF);
    we = 8'h04; inc = 8'h04; c_bus_in = 16'h5A5A;
    step();
    we = '0; inc = '0;
    chk("r2_we_prio", 32'(mux_out), 32'h5A5A);

    // Independent simultaneous updates
    inc = 8'h01; dec = 8'h02;
    step();
    inc = '0; dec = '0;
    setsel(4'd0);
    chk("r0_inc", 32'(mux_out), 32'h0001);
    setsel(4'd1);
    chk("r1_dec", 32'(mux_out), 32'hFFFF);
    setsel(4'd3);
    chk("r3_untouched", 32'(mux_out), 32'h1234);
    chk("zero_flags", 32'(reg_zero), 32'hF0);

    // Read transaction, ack on the fourth busy cycle
    ar_we = 1'b1; c_bus_in = 16'h0040;
    step();
    ar_we = 1'b0;
    setsel(4'd9);
    chk("ar_load", 32'(mux_out), 32'h0040);
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      #1;
      if (mem_req) req_cycles++;
      chk("rd_addr", 32'(mem_addr), 32'h0040);
      chk("rd_we", 32'(mem_we), 32'h0);
      step();
    end
    mem_ack = 1'b0;
    chk("rd_req_cycles", 32'(req_cycles), 32'd4);
    chk("rd_busy_done", 32'(busy), 32'h0);
    setsel(4'd8);
    chk("rd_dr", 32'(mux_out), 32'hBEEF);

    // Write transaction with ignored requests while busy
    dr_we = 1'b1; c_bus_in = 16'h00A5;
    step();
    dr_we = 1'b0; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
    ar_we = 1'b1; dr_we = 1'b1; mem_rd = 1'b1; c_bus_in = 16'h1111;
    step();
    ar_we = 1'b0; dr_we = 1'b0; mem_rd = 1'b0;
    chk("wr_addr", 32'(mem_addr), 32'h0040);
    chk("wr_wdata", 32'(mem_wdata), 32'h00A5);
    chk("wr_we", 32'(mem_we), 32'h1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_done", 32'(busy), 32'h0);
    step();
    chk("wr_no_read", 32'(busy), 32'h0);

    // Ack in IDLE ignored
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_busy", 32'(busy), 32'h0);
    chk("idle_ack_dr", 32'(mux_out), 32'h00A5);

    // Back-to-back read then write
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1357;
    step();
    mem_ack = 1'b0; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
    chk("b2b_we", 32'(mem_we), 32'h1);
    chk("b2b_wdata", 32'(mem_wdata), 32'h1357);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("b2b_done", 32'(busy), 32'h0);

    // IR load coincident with read ack
    dr_we = 1'b1; c_bus_in = 16'h0015;
    step();
    dr_we = 1'b0; mem_rd = 1'b1;
    step();
    mem_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h003F; ir_ld = 1'b1;
    step();
    mem_ack = 1'b0; ir_ld = 1'b0;
    chk("ir_pre_ack", 32'(ir_out), 32'h15);
    chk("ir_dr_new", 32'(mux_out), 32'h003F);
    setsel(4'd10);
    chk("sel_oob10", 32'(mux_out), 32'h0);
    setsel(4'd15);
    chk("sel_oob15", 32'(mux_out), 32'h0);
    ir_ld = 1'b1;
    step();
    ir_ld = 1'b0;
    chk("ir_reload", 32'(ir_out), 32'h3F);

    // Reset in the middle of a read
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0;
    chk("mid_req", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    setsel(4'd8);
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    chk("mid_rst_dr", 32'(mux_out), 32'h0);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    rst_n = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_dr", 32'(mux_out), 32'h0);
    chk("post_rst_ir", 32'(ir_out), 32'h0);
    chk("post_rst_zero", 32'(reg_zero), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
